// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter merging ALU and load writebacks onto one register-file write port,
// with a busy scoreboard tracking registers reserved by issue and not yet written back.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [4:0]            req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [4:0]            req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  reg_we,
  output logic [4:0]            reg_waddr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  input  logic                  claim_valid,
  input  logic [4:0]            claim_addr,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  // 1: requester 1 won most recently, so requester 0 wins the next contention
  logic                  r_last_grant;
  logic                  r_we;
  logic [4:0]            r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [31:1]           r_busy;

  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_accept;
  logic [4:0]            w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [31:1]           w_busy_d;
  logic [31:0]           w_busy_full;

  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        w_grant0 = r_last_grant;
        w_grant1 = !r_last_grant;
      end else begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign w_accept   = w_grant0 | w_grant1;
  assign w_addr     = w_grant1 ? req1_addr : req0_addr;
  assign w_data     = w_grant1 ? req1_data : req0_data;

  // Claim takes priority over the writeback clear of the same register
  always_comb begin
    w_busy_d = r_busy;
    for (int i = 1; i < 32; i++) begin
      w_busy_d[i] = (claim_valid && (claim_addr == 5'(i))) ||
                    (r_busy[i] && !(r_we && (r_waddr == 5'(i))));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_busy       <= '0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_grant1;
      end
      r_we <= w_accept && (w_addr != 5'd0);
      if (w_accept && (w_addr != 5'd0)) begin
        r_waddr <= w_addr;
        r_wdata <= w_data;
      end
      r_busy <= w_busy_d;
    end
  end

  assign reg_we      = r_we;
  assign reg_waddr   = r_waddr;
  assign reg_wdata   = r_wdata;
  assign w_busy_full = {r_busy, 1'b0};
  assign rs1_busy    = w_busy_full[rs1_addr];
  assign rs2_busy    = w_busy_full[rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of arbitration, writeback and scoreboard.
module tb_regfile_wb_arbiter;

  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0_valid = 1'b0;
  logic [4:0]    req0_addr = '0;
  logic [DW-1:0] req0_data = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [4:0]    req1_addr = '0;
  logic [DW-1:0] req1_data = '0;
  logic          req1_ready;
  logic          reg_we;
  logic [4:0]    reg_waddr;
  logic [DW-1:0] reg_wdata;
  logic          claim_valid = 1'b0;
  logic [4:0]    claim_addr = '0;
  logic [4:0]    rs1_addr = '0;
  logic [4:0]    rs2_addr = '0;
  logic          rs1_busy;
  logic          rs2_busy;

  int n_cmp = 0;
  int n_fail = 0;

  regfile_wb_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .reg_we     (reg_we),
    .reg_waddr  (reg_waddr),
    .reg_wdata  (reg_wdata),
    .claim_valid(claim_valid),
    .claim_addr (claim_addr),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1ns after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    claim_valid = 1'b0;
    rs1_addr = '0;
    rs2_addr = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd3;
    req1_valid = 1'b1; req1_addr = 5'd4;
    claim_valid = 1'b1; claim_addr = 5'd8;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b%b need 00", req0_ready, req1_ready);
    end
    tick();
    idle_inputs();
    rst = 1'b0;
    n_cmp++;
    if (reg_we !== 1'b0 || reg_waddr !== 5'd0 || reg_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_wport: got we=%b a=%0d d=%h need 0/0/0", reg_we, reg_waddr, reg_wdata);
    end
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      #1;
      n_cmp++;
      if (rs1_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_busy[%0d]: got %b need 0", i, rs1_busy);
      end
    end
    rs1_addr = '0;
  endtask

  task automatic test_single;
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 64'h11;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ready: got %b%b need 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    n_cmp++;
    if (reg_we !== 1'b1 || reg_waddr !== 5'd5 || reg_wdata !== 64'h11) begin
      n_fail++;
      $display("FAIL single_write: got we=%b a=%0d d=%h need 1/5/11", reg_we, reg_waddr, reg_wdata);
    end
    tick();
    n_cmp++;
    if (reg_we !== 1'b0 || reg_waddr !== 5'd5 || reg_wdata !== 64'h11) begin
      n_fail++;
      $display("FAIL idle_hold: got we=%b a=%0d d=%h need 0/5/11", reg_we, reg_waddr, reg_wdata);
    end
  endtask

  task automatic test_round_robin;
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 64'hA1;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 64'hA2;
    for (int i = 0; i < 4; i++) begin
      logic       g1;
      logic [4:0] ea;
      g1 = (i % 2) == 1;
      ea = g1 ? 5'd2 : 5'd1;
      #1;
      n_cmp++;
      if (req0_ready !== !g1 || req1_ready !== g1) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got %b%b need %b%b", i, req0_ready, req1_ready, !g1, g1);
      end
      tick();
      n_cmp++;
      if (reg_we !== 1'b1 || reg_waddr !== ea) begin
        n_fail++;
        $display("FAIL rr_write%0d: got we=%b a=%0d need 1/%0d", i, reg_we, reg_waddr, ea);
      end
    end
    idle_inputs();
  endtask

  task automatic test_x0;
    do_reset();
    claim_valid = 1'b1; claim_addr = 5'd6;
    tick();
    claim_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 64'hFF;
    rs1_addr = 5'd6;
    #1;
    n_cmp++;
    if (req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_ready: got %b need 1", req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    n_cmp++;
    if (reg_we !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_we: got %b need 0", reg_we);
    end
    tick();
    n_cmp++;
    if (rs1_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_busy_kept: got %b need 1", rs1_busy);
    end
    // x0 write should have moved the pointer: req0 now wins contention
    req0_valid = 1'b1; req0_addr = 5'd1;
    req1_valid = 1'b1; req1_addr = 5'd2;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_pointer: got %b%b need 10", req0_ready, req1_ready);
    end
    idle_inputs();
  endtask

  task automatic test_scoreboard;
    do_reset();
    claim_valid = 1'b1; claim_addr = 5'd7;
    rs1_addr = 5'd7;
    #1;
    n_cmp++;
    if (rs1_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL claim_no_bypass: got %b need 0", rs1_busy);
    end
    tick();
    claim_valid = 1'b0;
    n_cmp++;
    if (rs1_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL claim_set: got %b need 1", rs1_busy);
    end
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 64'h77;
    tick();
    req0_valid = 1'b0;
    n_cmp++;
    if (reg_we !== 1'b1 || reg_waddr !== 5'd7 || rs1_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wb_pending: got we=%b a=%0d busy=%b need 1/7/1", reg_we, reg_waddr, rs1_busy);
    end
    tick();
    n_cmp++;
    if (rs1_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_clear: got %b need 0", rs1_busy);
    end
  endtask

  task automatic test_set_clear;
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 64'h99;
    tick();
    req0_valid = 1'b0;
    claim_valid = 1'b1; claim_addr = 5'd9;
    n_cmp++;
    if (reg_we !== 1'b1 || reg_waddr !== 5'd9) begin
      n_fail++;
      $display("FAIL sc_write: got we=%b a=%0d need 1/9", reg_we, reg_waddr);
    end
    tick();
    claim_addr = 5'd0;
    rs1_addr = 5'd9; rs2_addr = 5'd0;
    #1;
    n_cmp++;
    if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL set_wins: got rs1=%b rs2=%b need 1/0", rs1_busy, rs2_busy);
    end
    tick();
    claim_valid = 1'b0;
    n_cmp++;
    if (rs2_busy !== 1'b0 || rs1_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL claim_x0: got rs2=%b rs1=%b need 0/1", rs2_busy, rs1_busy);
    end
    // writeback to a register that was never claimed leaves it idle
    req1_valid = 1'b1; req1_addr = 5'd12;
    rs2_addr = 5'd12;
    tick();
    req1_valid = 1'b0;
    tick();
    n_cmp++;
    if (rs2_busy !== 1'b0 || rs1_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_idle: got rs2=%b rs1=%b need 0/1", rs2_busy, rs1_busy);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid;
    do_reset();
    claim_valid = 1'b1; claim_addr = 5'd3;
    tick();
    claim_addr = 5'd4;
    req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 64'h55;
    tick();
    claim_valid = 1'b0; req1_valid = 1'b0;
    rs1_addr = 5'd3; rs2_addr = 5'd4;
    #1;
    n_cmp++;
    if (reg_we !== 1'b1 || rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: got we=%b b3=%b b4=%b need 1/1/1", reg_we, rs1_busy, rs2_busy);
    end
    rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd1;
    req1_valid = 1'b1; req1_addr = 5'd2;
    claim_valid = 1'b1; claim_addr = 5'd10;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_ready: got %b%b need 00", req0_ready, req1_ready);
    end
    tick();
    rst = 1'b0;
    claim_valid = 1'b0;
    #1;
    n_cmp++;
    if (reg_we !== 1'b0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_post: got we=%b b3=%b b4=%b need 0/0/0", reg_we, rs1_busy, rs2_busy);
    end
    rs1_addr = 5'd10;
    #1;
    n_cmp++;
    if (rs1_busy !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_claim_grant: got b10=%b rdy=%b%b need 0/10", rs1_busy, req0_ready,
               req1_ready);
    end
    idle_inputs();
  endtask

  task automatic test_random;
    int            m_last;
    bit            m_busy[32];
    bit            m_we;
    logic [4:0]    m_waddr;
    logic [DW-1:0] m_wdata;
    do_reset();
    m_last = 1;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int winner;
      bit e0, e1, eb1, eb2;
      rst = ($urandom_range(0, 99) < 3);
      req0_valid = $urandom_range(0, 1);
      req1_valid = $urandom_range(0, 1);
      req0_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      req1_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      req0_data = {$urandom, $urandom};
      req1_data = {$urandom, $urandom};
      claim_valid = $urandom_range(0, 1);
      claim_addr = 5'($urandom);
      rs1_addr = ($urandom_range(0, 1) == 1) ? m_waddr : 5'($urandom);
      rs2_addr = 5'($urandom);
      #1;
      if (rst) winner = -1;
      else if (req0_valid && req1_valid) winner = 1 - m_last;
      else if (req0_valid) winner = 0;
      else if (req1_valid) winner = 1;
      else winner = -1;
      e0 = (winner == 0);
      e1 = (winner == 1);
      eb1 = m_busy[rs1_addr] && (rs1_addr != 0);
      eb2 = m_busy[rs2_addr] && (rs2_addr != 0);
      n_cmp++;
      if (req0_ready !== e0 || req1_ready !== e1) begin
        n_fail++;
        $display("FAIL rnd_ready c%0d: got %b%b need %b%b", cyc, req0_ready, req1_ready, e0, e1);
      end
      n_cmp++;
      if (rs1_busy !== eb1 || rs2_busy !== eb2) begin
        n_fail++;
        $display("FAIL rnd_busy c%0d: got %b%b need %b%b", cyc, rs1_busy, rs2_busy, eb1, eb2);
      end
      if (rst) begin
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_last = 1; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
      end else begin
        if (m_we) m_busy[m_waddr] = 1'b0;
        if (claim_valid && claim_addr != 0) m_busy[claim_addr] = 1'b1;
        m_we = 1'b0;
        if (winner >= 0) begin
          logic [4:0]    wa;
          logic [DW-1:0] wd;
          wa = (winner == 1) ? req1_addr : req0_addr;
          wd = (winner == 1) ? req1_data : req0_data;
          m_last = winner;
          if (wa != 0) begin
            m_we = 1'b1; m_waddr = wa; m_wdata = wd;
          end
        end
      end
      tick();
      n_cmp++;
      if (reg_we !== m_we || (m_we && (reg_waddr !== m_waddr || reg_wdata !== m_wdata))) begin
        n_fail++;
        $display("FAIL rnd_wport c%0d: got %b/%0d/%h need %b/%0d/%h", cyc, reg_we, reg_waddr,
                 reg_wdata, m_we, m_waddr, m_wdata);
      end
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_x0();
    test_scoreboard();
    test_set_clear();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
